// File: rtl/pe_dot_accumulator.sv
// pe_dot_accumulator
//   Reduction stage behind the 4-lane dot-product PE. A job starts from a
//   signed bias. It adds a programmed number of unsigned PE partial sums,
//   one per accepted beat. It then presents the result on a valid/ready
//   output.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      job start pulse, honoured only in IDLE
//   len        beat count for the job, captured with start
//   bias       signed initial accumulator value, captured with start
//   busy       high whenever a job is in progress (state != IDLE)
//   in_valid   PE partial sum valid
//   in_ready   accumulator accepts a beat (ACC state only)
//   in_c       PE partial sum, unsigned
//   out_valid  result valid (DONE state only)
//   out_ready  downstream accepts the result
//   out_data   accumulated result, holds its value after the handshake
module pe_dot_accumulator #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 16,
  parameter int IN_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [ACC_W-1:0] bias,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [LEN_W-1:0] remaining, remaining_next;
  logic [ACC_W-1:0] result, result_next;
  logic [ACC_W-1:0] sum;
  logic             beat;

  // Handshake flags are pure state decodes, so no input reaches them
  // combinationally.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign out_data  = result;

  assign beat = in_valid && (state == ACC);
  assign sum  = acc + {{(ACC_W-IN_W){1'b0}}, in_c};

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    remaining_next = remaining;
    result_next    = result;
    case (state)
      IDLE: begin
        if (start) begin
          acc_next = bias;
          if (len == '0) begin
            // Empty job: the bias itself is the result.
            result_next = bias;
            state_next  = DONE;
          end else begin
            remaining_next = len;
            state_next     = ACC;
          end
        end
      end
      ACC: begin
        if (beat) begin
          acc_next       = sum;
          remaining_next = remaining - {{(LEN_W-1){1'b0}}, 1'b1};
          if (remaining == {{(LEN_W-1){1'b0}}, 1'b1}) begin
            // The result is latched into a separate register. A later
            // start reloads acc, but out_data keeps the last result.
            result_next = sum;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      result    <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      remaining <= remaining_next;
      result    <= result_next;
    end
  end

endmodule

// File: tb/tb_pe_dot_accumulator.sv
module tb_pe_dot_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic [31:0] bias;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int tests_run    = 0;
  int tests_failed = 0;

  pe_dot_accumulator dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] l, input logic [31:0] b);
    start = 1'b1;
    len   = l;
    bias  = b;
    step();
    start = 1'b0;
    len   = 16'hAAAA;
    bias  = 32'h5555_5555;
  endtask

  task automatic beat(input logic [9:0] c);
    in_valid = 1'b1;
    in_c     = c;
    step();
    in_valid = 1'b0;
    in_c     = 10'h3FF;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; in_c = '0; out_ready = 1'b0;
    step();
    step();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data", out_data, 32'd0);
    reset = 1'b0;
    step();

    // Basic job: 4 x 900 = 3600.
    out_ready = 1'b1;
    do_start(16'd4, 32'd0);
    check("basic busy", {31'd0, busy}, 32'd1);
    check("basic in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      beat(10'd900);
      check("basic mid out_valid", {31'd0, out_valid}, 32'd0);
    end
    beat(10'd900);
    check("basic out_valid", {31'd0, out_valid}, 32'd1);
    check("basic out_data", out_data, 32'd3600);
    check("basic done in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("basic idle busy", {31'd0, busy}, 32'd0);
    check("basic idle out_valid", {31'd0, out_valid}, 32'd0);
    check("basic retained out_data", out_data, 32'd3600);

    // Signed bias with gaps: -5 + 3 + 0 + 1 = -1.
    do_start(16'd3, 32'hFFFF_FFFB);
    beat(10'd3);
    idle_cycles(2);
    check("gap in_ready", {31'd0, in_ready}, 32'd1);
    check("gap out_valid", {31'd0, out_valid}, 32'd0);
    beat(10'd0);
    idle_cycles(2);
    check("gap2 out_valid", {31'd0, out_valid}, 32'd0);
    beat(10'd1);
    check("signed out_valid", {31'd0, out_valid}, 32'd1);
    check("signed out_data", out_data, 32'hFFFF_FFFF);
    step();

    // Zero length: the result is the bias and no beat is accepted.
    do_start(16'd0, 32'h0000_0123);
    check("zero in_ready", {31'd0, in_ready}, 32'd0);
    check("zero out_valid", {31'd0, out_valid}, 32'd1);
    check("zero out_data", out_data, 32'h0000_0123);
    step();
    check("zero idle busy", {31'd0, busy}, 32'd0);

    // Backpressure: 10 + 5 = 15 held for 5 cycles; a start in DONE is ignored.
    out_ready = 1'b0;
    do_start(16'd1, 32'd10);
    beat(10'd5);
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp out_data", out_data, 32'd15);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      if (i == 2) do_start(16'd1, 32'd99);
      else step();
    end
    out_ready = 1'b1;
    step();
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release busy", {31'd0, busy}, 32'd0);
    check("bp release out_data", out_data, 32'd15);

    // Wrap-around: 0xFFFFFFFF + 1 + 5 = 5.
    do_start(16'd2, 32'hFFFF_FFFF);
    beat(10'd1);
    beat(10'd5);
    check("wrap out_valid", {31'd0, out_valid}, 32'd1);
    check("wrap out_data", out_data, 32'h0000_0005);
    step();

    // Reset mid-job: the partial result is abandoned.
    do_start(16'd4, 32'd0);
    beat(10'd900);
    beat(10'd900);
    #2 reset = 1'b1;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst out_data", out_data, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst quiet out_valid", {31'd0, out_valid}, 32'd0);
    end
    do_start(16'd1, 32'd0);
    beat(10'd7);
    check("post-reset out_valid", {31'd0, out_valid}, 32'd1);
    check("post-reset out_data", out_data, 32'd7);
    step();
    check("post-reset idle busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
